// File: rtl/storage_access_arbiter.sv
// storage_access_arbiter
// Shares the single read/write id port pair of the chart/record storage
// managers among NREQ requesters. A round-robin arbiter picks one eligible
// requester in IDLE, the transaction FSM pulses rd_id or wr_id for one cycle,
// waits out the storage read latency and returns a one-cycle done to the
// winner. Payload data stays external; the top level muxes it with gnt_idx.
// All outputs are registered: every output flop is loaded from the value the
// output must have in the state being entered.

module storage_access_arbiter #(
  parameter int NREQ   = 3,  // number of requesters (2..8)
  parameter int ID_W   = 8,  // slot id width
  parameter int RD_LAT = 1,  // id-sampling edge to read-data-valid, in cycles (>=1)
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 sys_rst,   // asynchronous, active-low
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*ID_W-1:0] req_id,
  output logic [NREQ-1:0]      gnt,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic [NREQ-1:0]      done,
  output logic [ID_W-1:0]      rd_id,
  output logic [ID_W-1:0]      wr_id,
  output logic                 busy
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // FSM / bookkeeping flops
  state_e             state_q,   state_d;
  logic [IDX_W-1:0]   ptr_q,     ptr_d;     // last winner; scan starts at ptr+1
  logic [IDX_W-1:0]   idx_q,     idx_d;     // winner of the running transaction
  logic               we_q,      we_d;      // its direction, sampled at grant
  logic [CNT_W-1:0]   cnt_q,     cnt_d;     // remaining read-latency cycles

  // registered outputs
  logic [NREQ-1:0]    gnt_q,     gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [NREQ-1:0]    done_q,    done_d;
  logic [ID_W-1:0]    rd_id_q,   rd_id_d;
  logic [ID_W-1:0]    wr_id_q,   wr_id_d;
  logic               busy_q,    busy_d;

  // arbiter results
  logic [NREQ-1:0]    elig;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               win_we;
  logic [ID_W-1:0]    win_id;
  int                 cand;

  // Eligibility: a live request carrying a nonzero id (id 0 is reserved).
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req[i] && (req_id[i*ID_W +: ID_W] != '0);
    end
  end

  // Round-robin pick: first eligible index scanning ptr+1, ptr+2, ... mod NREQ.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr_q) + k) % NREQ;
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
    win_we = req_we[win_idx];
    win_id = req_id[int'(win_idx)*ID_W +: ID_W];
  end

  // Transaction FSM next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    done_d    = '0;   // done is a single-cycle pulse
    rd_id_d   = '0;   // ids are nonzero only in the ISSUE cycle
    wr_id_d   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d          = ST_ISSUE;
          ptr_d            = win_idx;
          idx_d            = win_idx;
          we_d             = win_we;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          gnt_idx_d        = win_idx;
          // The id is captured into the output flop here, so later changes
          // on req_id cannot reach the storage port.
          if (win_we) wr_id_d = win_id;
          else        rd_id_d = win_id;
        end
      end

      ST_ISSUE: begin
        if (we_q || RD_LAT == 1) begin
          state_d       = ST_DONE;
          done_d[idx_q] = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
        end
      end

      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d       = ST_DONE;
          done_d[idx_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= IDX_W'(NREQ - 1);  // requester 0 wins first after reset
      idx_q     <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      done_q    <= '0;
      rd_id_q   <= '0;
      wr_id_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      done_q    <= done_d;
      rd_id_q   <= rd_id_d;
      wr_id_q   <= wr_id_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign done    = done_q;
  assign rd_id   = rd_id_q;
  assign wr_id   = wr_id_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_storage_access_arbiter.sv
// Testbench for storage_access_arbiter. Two instances share one stimulus:
// u_lat1 (RD_LAT=1) and u_lat3 (RD_LAT=3). A timeline model predicts, for each
// instance, the output vector of every cycle: when a transaction is granted it
// queues the whole ISSUE / WAIT.. / DONE output sequence at once. A monitor
// compares both DUTs against it every cycle; directed steps add literal checks.

module tb_storage_access_arbiter;

  localparam int NREQ = 3;
  localparam int ID_W = 8;

  logic                 clk;
  logic                 sys_rst;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_we;
  logic [NREQ*ID_W-1:0] req_id;

  logic [2:0] gnt1, done1, gnt3, done3;
  logic [1:0] gidx1, gidx3;
  logic [7:0] rd1, wr1, rd3, wr3;
  logic       busy1, busy3;

  int checks = 0;
  int errors = 0;

  storage_access_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .RD_LAT(1)) u_lat1 (
    .clk(clk), .sys_rst(sys_rst), .req(req), .req_we(req_we), .req_id(req_id),
    .gnt(gnt1), .gnt_idx(gidx1), .done(done1), .rd_id(rd1), .wr_id(wr1), .busy(busy1)
  );

  storage_access_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .RD_LAT(3)) u_lat3 (
    .clk(clk), .sys_rst(sys_rst), .req(req), .req_we(req_we), .req_id(req_id),
    .gnt(gnt3), .gnt_idx(gidx3), .done(done3), .rd_id(rd3), .wr_id(wr3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  typedef struct packed {
    logic [2:0] gnt;
    logic [1:0] gnt_idx;
    logic [2:0] done;
    logic [7:0] rd;
    logic [7:0] wr;
    logic       busy;
    logic       idle;
  } out_t;

  out_t cur [2];
  out_t sched [2][$];
  int   ptr [2];
  int   lat [2] = '{1, 3};

  task automatic model_reset(input int m);
    cur[m]      = '0;
    cur[m].idle = 1'b1;
    sched[m].delete();
    ptr[m]      = NREQ - 1;
  endtask

  // Advance one clock edge, given the inputs the DUT sampled on that edge.
  task automatic model_step(input int m, input logic [2:0] r, input logic [2:0] we,
                            input logic [23:0] ids);
    out_t o;
    int   w;
    logic [7:0] id;
    if (sched[m].size() > 0) begin
      cur[m] = sched[m].pop_front();
      return;
    end
    if (!cur[m].idle) begin        // leaving DONE: back to idle, index kept
      o         = '0;
      o.idle    = 1'b1;
      o.gnt_idx = cur[m].gnt_idx;
      cur[m]    = o;
      return;
    end
    w = -1;
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (ptr[m] + k) % NREQ;
      if (w < 0 && r[c] && ids[c*8 +: 8] != 8'd0) w = c;
    end
    if (w < 0) return;             // nobody eligible: outputs unchanged
    ptr[m] = w;
    id     = ids[w*8 +: 8];
    o         = '0;
    o.gnt     = 3'(1 << w);
    o.gnt_idx = 2'(w);
    o.busy    = 1'b1;
    if (we[w]) o.wr = id;
    else       o.rd = id;
    sched[m].push_back(o);         // ISSUE
    o.rd = '0;
    o.wr = '0;
    if (!we[w]) begin
      for (int k = 0; k < lat[m] - 1; k++) sched[m].push_back(o);  // WAIT
    end
    o.done = 3'(1 << w);
    sched[m].push_back(o);         // DONE
    cur[m] = sched[m].pop_front();
  endtask

  task automatic compare(input int m, input logic [2:0] g, input logic [1:0] gi,
                         input logic [2:0] d, input logic [7:0] rd, input logic [7:0] wr,
                         input logic b);
    string p;
    p = (m == 0) ? "lat1" : "lat3";
    check({p, ".gnt"},     32'(g),  32'(cur[m].gnt));
    check({p, ".gnt_idx"}, 32'(gi), 32'(cur[m].gnt_idx));
    check({p, ".done"},    32'(d),  32'(cur[m].done));
    check({p, ".rd_id"},   32'(rd), 32'(cur[m].rd));
    check({p, ".wr_id"},   32'(wr), 32'(cur[m].wr));
    check({p, ".busy"},    32'(b),  32'(cur[m].busy));
    check({p, ".mutex"},   32'((rd != 8'd0) && (wr != 8'd0)), 32'd0);
  endtask

  // Monitor: advance the model on each edge, compare mid-cycle.
  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
        if (!sys_rst) model_reset(m);
        else          model_step(m, req, req_we, req_id);
      end
      @(negedge clk);
      for (int m = 0; m < 2; m++) if (!sys_rst) model_reset(m);
      compare(0, gnt1, gidx1, done1, rd1, wr1, busy1);
      compare(1, gnt3, gidx3, done3, rd3, wr3, busy3);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_wait(input int n);
    req = '0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    sys_rst = 1'b1;
    req     = '0;
    req_we  = '0;
    req_id  = '0;
    #2 sys_rst = 1'b0;
    cyc();
    cyc();
    check("reset.busy", 32'(busy1), 32'd0);
    check("reset.gnt",  32'(gnt1),  32'd0);

    // Round robin right after reset: all three read-request continuously.
    req_id = {8'd3, 8'd2, 8'd1};
    req_we = 3'b000;
    req    = 3'b111;
    sys_rst = 1'b1;                              // cycle 0 (IDLE)
    for (int c = 1; c <= 18; c++) begin
      cyc();
      if (c % 3 == 1) check("rr.gnt_idx", 32'(gidx1), 32'((c / 3) % 3));
      if (c % 3 == 2) check("rr.done",    32'(done1), 32'(1 << ((c / 3) % 3)));
    end
    idle_wait(8);

    // Single read by requester 1, id 2.
    req_id = {8'd0, 8'd2, 8'd0};
    req_we = 3'b000;
    req    = 3'b010;
    cyc();                                       // cycle 1: ISSUE
    check("rd.rd_id",   32'(rd1),   32'd2);
    check("rd.gnt_idx", 32'(gidx1), 32'd1);
    check("rd.done1",   32'(done1), 32'd0);
    check("rd3.rd_id",  32'(rd3),   32'd2);
    req = 3'b000;
    cyc();                                       // cycle 2
    check("rd.done",    32'(done1), 32'b010);
    check("rd.rd_off",  32'(rd1),   32'd0);
    req_id = {8'd0, 8'd9, 8'd0};                 // changed during WAIT of lat3
    cyc();                                       // cycle 3
    check("rd3.wait_rd", 32'(rd3),  32'd0);
    check("rd3.busy",    32'(busy3), 32'd1);
    check("rd3.nodone",  32'(done3), 32'd0);
    cyc();                                       // cycle 4
    check("rd3.done",    32'(done3), 32'b010);
    idle_wait(6);

    // Single write by requester 0, id 3.
    req_id = {8'd0, 8'd0, 8'd3};
    req_we = 3'b001;
    req    = 3'b001;
    cyc();
    check("wr.wr_id", 32'(wr1), 32'd3);
    check("wr.rd_id", 32'(rd1), 32'd0);
    req = 3'b000;
    cyc();
    check("wr.done",  32'(done1), 32'b001);
    check("wr.off",   32'(wr1),   32'd0);
    idle_wait(6);

    // Id 0 is never granted.
    req_id = {8'd0, 8'd0, 8'd0};
    req_we = 3'b000;
    req    = 3'b100;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("id0.busy", 32'(busy1), 32'd0);
      check("id0.gnt",  32'(gnt1),  32'd0);
    end

    // Requester 1 drops its request during ISSUE; done still arrives.
    req_id = {8'd0, 8'd5, 8'd0};
    req    = 3'b010;
    cyc();
    req = 3'b000;
    cyc();
    check("drop.done", 32'(done1), 32'b010);
    idle_wait(6);

    // Reset mid-WAIT of the RD_LAT=3 instance.
    req_id = {8'd6, 8'd0, 8'd4};
    req_we = 3'b000;
    req    = 3'b001;
    cyc();                                       // ISSUE
    req = 3'b000;
    cyc();                                       // lat3 in WAIT
    sys_rst = 1'b0;
    #1;
    check("rst.busy3",  32'(busy3), 32'd0);
    check("rst.gnt3",   32'(gnt3),  32'd0);
    check("rst.gidx3",  32'(gidx3), 32'd0);
    check("rst.done3",  32'(done3), 32'd0);
    check("rst.rd3",    32'(rd3),   32'd0);
    req = 3'b101;
    cyc();
    sys_rst = 1'b1;                              // cycle 0 (IDLE)
    cyc();
    check("rst.first_idx", 32'(gidx1), 32'd0);
    check("rst.first_gnt", 32'(gnt3),  32'b001);
    idle_wait(8);

    // Randomized phase with occasional one-cycle resets.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      sys_rst = ($urandom_range(0, 299) != 0);
      req     = 3'($urandom_range(0, 7));
      req_we  = 3'($urandom_range(0, 7));
      for (int j = 0; j < NREQ; j++) begin
        req_id[j*8 +: 8] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      end
    end
    sys_rst = 1'b1;
    idle_wait(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
